// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter:
// FSM state encoding and requester indices.
package cpu_inst_types;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  localparam int REQ_CPU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int CNT_W    = 4;

endpackage

// File: rtl/mem_bus_arbiter_rr_select.sv
// Two-way round-robin winner select.
// A tie goes to the requester not granted last.
module arb_rr_select
  import cpu_inst_types::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  // Lone requester wins; a tie alternates on last.
  always_comb begin
    win = 2'b00;
    unique case (req)
      2'b01: win[REQ_CPU] = 1'b1;
      2'b10: win[REQ_LOAD] = 1'b1;
      2'b11: begin
        if (last == 1'b1) win[REQ_CPU] = 1'b1;
        else win[REQ_LOAD] = 1'b1;
      end
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter with a fixed
// MEM_LAT-cycle access window and a one-cycle done.
module mem_bus_arbiter
  import cpu_inst_types::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [31:0] mem_rdata,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we
);

  localparam logic [CNT_W-1:0] LOAD =
    CNT_W'(MEM_LAT - 1);

  arb_state_t       state;
  arb_state_t       state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             last;
  logic             last_nx;
  logic [1:0]       grant;
  logic [1:0]       grant_nx;
  logic [1:0]       fin;
  logic [1:0]       fin_nx;
  logic [31:0]      rd_data;
  logic [31:0]      rd_data_nx;
  logic [31:0]      bus_addr;
  logic [31:0]      bus_addr_nx;
  logic [31:0]      bus_wdata;
  logic [31:0]      bus_wdata_nx;
  logic             bus_we;
  logic             bus_we_nx;
  logic [1:0]       win;
  logic             last_beat;

  assign last_beat = (cnt == '0);

  arb_rr_select u_sel (
    .req  ({req1, req0}),
    .last (last),
    .win  (win)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end

  // Next state: IDLE -> ACCESS -> DONE -> IDLE.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req0 || req1) state_nx = ACCESS;
      ACCESS:  if (last_beat) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of counter, pointer and bus outputs.
  always_comb begin
    cnt_nx       = cnt;
    last_nx      = last;
    grant_nx     = grant;
    fin_nx       = 2'b00;
    rd_data_nx   = rd_data;
    bus_addr_nx  = bus_addr;
    bus_wdata_nx = bus_wdata;
    bus_we_nx    = bus_we;
    unique case (state)
      IDLE: begin
        if (win != 2'b00) begin
          cnt_nx   = LOAD;
          last_nx  = win[REQ_LOAD];
          grant_nx = win;
          if (win[REQ_LOAD]) begin
            bus_addr_nx  = addr1;
            bus_wdata_nx = wdata1;
            bus_we_nx    = we1;
          end else begin
            bus_addr_nx  = addr0;
            bus_wdata_nx = wdata0;
            bus_we_nx    = we0;
          end
        end
      end
      ACCESS: begin
        if (last_beat) begin
          grant_nx  = 2'b00;
          bus_we_nx = 1'b0;
          fin_nx    = grant;
          if (!bus_we) rd_data_nx = mem_rdata;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      DONE: begin
        grant_nx  = 2'b00;
        bus_we_nx = 1'b0;
      end
      default: begin
        grant_nx  = 2'b00;
        bus_we_nx = 1'b0;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      last      <= 1'b1;
      grant     <= 2'b00;
      fin       <= 2'b00;
      rd_data   <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_we    <= 1'b0;
    end else begin
      cnt       <= cnt_nx;
      last      <= last_nx;
      grant     <= grant_nx;
      fin       <= fin_nx;
      rd_data   <= rd_data_nx;
      bus_addr  <= bus_addr_nx;
      bus_wdata <= bus_wdata_nx;
      bus_we    <= bus_we_nx;
    end
  end

  assign gnt0      = grant[REQ_CPU];
  assign gnt1      = grant[REQ_LOAD];
  assign done0     = fin[REQ_CPU];
  assign done1     = fin[REQ_LOAD];
  assign rdata     = rd_data;
  assign mem_addr  = bus_addr;
  assign mem_wdata = bus_wdata;
  assign mem_we    = bus_we;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter (MEM_LAT=2),
// plus latency probes on MEM_LAT=1 and MEM_LAT=15.
module tb_mem_bus_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic [31:0] mem_rdata = '0;

  logic        gnt0, gnt1, done0, done1, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;

  logic        a_gnt0, a_gnt1, a_done0, a_done1, a_we;
  logic [31:0] a_rdata, a_addr, a_wdata;
  logic        b_gnt0, b_gnt1, b_done0, b_done1, b_we;
  logic [31:0] b_rdata, b_addr, b_wdata;

  mem_bus_arbiter #(.MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .mem_rdata(mem_rdata),
    .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1),
    .rdata(rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we)
  );

  mem_bus_arbiter #(.MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .mem_rdata(mem_rdata),
    .gnt0(a_gnt0), .gnt1(a_gnt1),
    .done0(a_done0), .done1(a_done1),
    .rdata(a_rdata), .mem_addr(a_addr),
    .mem_wdata(a_wdata), .mem_we(a_we)
  );

  mem_bus_arbiter #(.MEM_LAT(15)) dut15 (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .mem_rdata(mem_rdata),
    .gnt0(b_gnt0), .gnt1(b_gnt1),
    .done0(b_done0), .done1(b_done1),
    .rdata(b_rdata), .mem_addr(b_addr),
    .mem_wdata(b_wdata), .mem_we(b_we)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        who;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          run = 0;
  logic        pg = 1'b0;
  logic [31:0] last_rd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic who, input logic we,
                      input logic [31:0] addr,
                      input logic [31:0] wd,
                      input int c0);
    exp_t e;
    e.who   = who;
    e.we    = we;
    e.addr  = addr;
    e.wdata = wd;
    if (!we) last_rd = mem_rdata;
    e.rdata = last_rd;
    e.cyc   = c0 + LAT + 1;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    last_rd = '0;
    #1;
    chk("rst_ctl", 32'({gnt0, gnt1, done0, done1, mem_we}), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    tick(1);
    reset = 1'b0;
  endtask

  // Scoreboard monitor on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      run = 0;
      pg  = 1'b0;
    end else begin
      chk("gnt_excl", 32'(gnt0 & gnt1), 0);
      chk("done_excl", 32'(done0 & done1), 0);
      chk("we_idle", 32'(mem_we & ~(gnt0 | gnt1)), 0);
      if ((gnt0 | gnt1) && !pg) begin
        if (sb.size() == 0) begin
          chk("gnt_spur", 32'({gnt1, gnt0}), 0);
        end else begin
          e = sb[0];
          chk("gnt_who", 32'(gnt1), 32'(e.who));
          chk("gnt_cyc", 32'(cyc), 32'(e.cyc - LAT));
          chk("gnt_addr", mem_addr, e.addr);
          chk("gnt_we", 32'(mem_we), 32'(e.we));
          if (e.we) chk("gnt_wdata", mem_wdata, e.wdata);
        end
      end
      if (gnt0 | gnt1) run++;
      if (done0 | done1) begin
        if (sb.size() == 0) begin
          chk("done_spur", 32'({done1, done0}), 0);
        end else begin
          e = sb.pop_front();
          chk("done_who", 32'(done1), 32'(e.who));
          chk("done_cyc", 32'(cyc), 32'(e.cyc));
          chk("done_rdata", rdata, e.rdata);
          chk("gnt_len", 32'(run), 32'(LAT));
        end
        run = 0;
      end
      pg = gnt0 | gnt1;
    end
  end

  initial begin
    int n;
    int d1;
    int d15;
    tick(1);
    do_reset();

    // Single read, also probes MEM_LAT 1 and 15.
    n = cyc;
    mem_rdata = 32'hCAFE_F00D;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h100;
    push(1'b1, 1'b0, 32'h100, 32'h0, n);
    d1 = -1;
    d15 = -1;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      if (cyc == n + 2) req1 = 1'b0;
      @(negedge clk);
      if (a_done1 && d1 < 0) d1 = cyc;
      if (b_done1 && d15 < 0) d15 = cyc;
    end
    chk("lat1", 32'(d1 - n), 2);
    chk("lat15", 32'(d15 - n), 16);
    chk("lat15_rd", b_rdata, 32'hCAFE_F00D);
    tick(1);

    // Write leaves rdata untouched.
    n = cyc;
    mem_rdata = 32'hDEAD_BEEF;
    req0 = 1'b1; we0 = 1'b1;
    addr0 = 32'h40; wdata0 = 32'h1234_5678;
    push(1'b0, 1'b1, 32'h40, 32'h1234_5678, n);
    tick(3);
    req0 = 1'b0; we0 = 1'b0;
    tick(20);

    // Both requesting continuously: 0,1,0.
    do_reset();
    n = cyc;
    mem_rdata = 32'h1111_2222;
    addr0 = 32'h200; addr1 = 32'h300;
    req0 = 1'b1; req1 = 1'b1;
    push(1'b0, 1'b0, 32'h200, 32'h0, n);
    push(1'b1, 1'b0, 32'h300, 32'h0, n + 4);
    push(1'b0, 1'b0, 32'h200, 32'h0, n + 8);
    tick(11);
    req0 = 1'b0; req1 = 1'b0;
    tick(20);

    // Reset in the second ACCESS cycle of a read.
    do_reset();
    n = cyc;
    mem_rdata = 32'hA5A5_A5A5;
    req1 = 1'b1; addr1 = 32'h500;
    push(1'b1, 1'b0, 32'h500, 32'h0, n);
    tick(2);
    chk("mid_gnt1", 32'(gnt1), 1);
    do_reset();
    n = cyc;
    push(1'b1, 1'b0, 32'h500, 32'h0, n);
    tick(2);
    req1 = 1'b0;
    tick(20);

    // Request dropped during ACCESS.
    n = cyc;
    mem_rdata = 32'h0BAD_F00D;
    req0 = 1'b1; addr0 = 32'h600;
    push(1'b0, 1'b0, 32'h600, 32'h0, n);
    tick(1);
    req0 = 1'b0;
    tick(10);
    chk("drop_nognt", 32'({gnt1, gnt0}), 0);

    chk("sb_drain", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
